// File: rtl/qpu_exu_oitf.sv
// rtl/qpu_exu_oitf.sv - outstanding instruction track FIFO for the QPU execute stage
//
// Records every long-pipe instruction issued by dispatch (classical loads/FMR
// that write rd, measures that set qubit flags) and retires them in order as
// they write back. Also provides hazard matches against the dispatching
// instruction so dispatch can stall RAW/WAW and qubit-flag conflicts.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   dis_ena / dis_ready         allocate request / at least one free entry
//   dis_rs1en, dis_rs2en        dispatching instruction reads rs1 / rs2
//   dis_rdwen, dis_qfren        dispatching instruction writes rd / sets qubit flags
//   dis_rs1idx/rs2idx/rdidx     register indices of the dispatching instruction
//   dis_qubitlist               qubit list of the dispatching instruction
//   dis_ptr                     tag of the entry being allocated
//   ret_ena                     head entry has written back, pop it
//   ret_ptr, ret_rdwen, ret_qfren, ret_rdidx, ret_qubitlist   head entry contents
//   oitf_empty                  no valid entries
//   oitfrd_match_disprs1/rs2/rd register hazard matches
//   oitfqf_match_dispql         qubit-flag overlap match

module qpu_exu_oitf #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int RFIDX_W   = 5,
    parameter int QUBIT_NUM = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 dis_ena,
    output logic                 dis_ready,
    input  logic                 dis_rs1en,
    input  logic                 dis_rs2en,
    input  logic                 dis_rdwen,
    input  logic                 dis_qfren,
    input  logic [RFIDX_W-1:0]   dis_rs1idx,
    input  logic [RFIDX_W-1:0]   dis_rs2idx,
    input  logic [RFIDX_W-1:0]   dis_rdidx,
    input  logic [QUBIT_NUM-1:0] dis_qubitlist,
    output logic [PTR_W-1:0]     dis_ptr,

    input  logic                 ret_ena,
    output logic [PTR_W-1:0]     ret_ptr,
    output logic                 ret_rdwen,
    output logic                 ret_qfren,
    output logic [RFIDX_W-1:0]   ret_rdidx,
    output logic [QUBIT_NUM-1:0] ret_qubitlist,

    output logic                 oitf_empty,
    output logic                 oitfrd_match_disprs1,
    output logic                 oitfrd_match_disprs2,
    output logic                 oitfrd_match_disprd,
    output logic                 oitfqf_match_dispql
);

    // Pointers carry one extra wrap bit above the index so full and empty
    // can be told apart when the indices coincide.
    logic [PTR_W:0]         alc_ptr_r;
    logic [PTR_W:0]         ret_ptr_r;

    logic [DEPTH-1:0]       valid_r;
    logic [DEPTH-1:0]       rdwen_r;
    logic [DEPTH-1:0]       qfren_r;
    logic [RFIDX_W-1:0]     rdidx_r     [DEPTH];
    logic [QUBIT_NUM-1:0]   qubitlist_r [DEPTH];

    logic                   full;
    logic                   empty;
    logic                   alc_fire;
    logic                   ret_fire;
    logic [PTR_W-1:0]       alc_idx;
    logic [PTR_W-1:0]       ret_idx;

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    assign alc_idx  = alc_ptr_r[PTR_W-1:0];
    assign ret_idx  = ret_ptr_r[PTR_W-1:0];
    assign full     = (alc_idx == ret_idx) && (alc_ptr_r[PTR_W] != ret_ptr_r[PTR_W]);
    assign empty    = (alc_ptr_r == ret_ptr_r);

    // Full is registered state, so a same-cycle retire never frees a slot
    // for a same-cycle allocate.
    assign alc_fire = dis_ena && !full;
    assign ret_fire = ret_ena && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr_r <= '0;
            ret_ptr_r <= '0;
            valid_r   <= '0;
            rdwen_r   <= '0;
            qfren_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdidx_r[i]     <= '0;
                qubitlist_r[i] <= '0;
            end
        end else begin
            // Allocate and retire never target the same entry: equal indices
            // mean full (no allocate) or empty (no retire).
            if (alc_fire) begin
                valid_r[alc_idx]     <= 1'b1;
                rdwen_r[alc_idx]     <= dis_rdwen;
                qfren_r[alc_idx]     <= dis_qfren;
                rdidx_r[alc_idx]     <= dis_rdidx;
                qubitlist_r[alc_idx] <= dis_qubitlist;
                alc_ptr_r            <= alc_ptr_r + PTR_ONE;
            end
            if (ret_fire) begin
                valid_r[ret_idx] <= 1'b0;
                ret_ptr_r        <= ret_ptr_r + PTR_ONE;
            end
        end
    end

    // Hazard matches look only at registered contents: an entry being
    // retired this cycle still matches, one being allocated does not yet.
    always_comb begin
        logic rs1_hit;
        logic rs2_hit;
        logic rd_hit;
        logic ql_hit;
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rd_hit  = 1'b0;
        ql_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && rdwen_r[i]) begin
                if (rdidx_r[i] == dis_rs1idx) rs1_hit = 1'b1;
                if (rdidx_r[i] == dis_rs2idx) rs2_hit = 1'b1;
                if (rdidx_r[i] == dis_rdidx)  rd_hit  = 1'b1;
            end
            if (valid_r[i] && qfren_r[i] && ((qubitlist_r[i] & dis_qubitlist) != '0)) begin
                ql_hit = 1'b1;
            end
        end
        oitfrd_match_disprs1 = rs1_hit && dis_rs1en;
        oitfrd_match_disprs2 = rs2_hit && dis_rs2en;
        oitfrd_match_disprd  = rd_hit  && dis_rdwen;
        oitfqf_match_dispql  = ql_hit;
    end

    assign dis_ready     = !full;
    assign oitf_empty    = empty;
    assign dis_ptr       = alc_idx;
    assign ret_ptr       = ret_idx;
    assign ret_rdwen     = rdwen_r[ret_idx];
    assign ret_qfren     = qfren_r[ret_idx];
    assign ret_rdidx     = rdidx_r[ret_idx];
    assign ret_qubitlist = qubitlist_r[ret_idx];

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// tb/tb_qpu_exu_oitf.sv - directed self-checking bench for qpu_exu_oitf

module tb_qpu_exu_oitf;

    logic       clk;
    logic       rst_n;
    logic       dis_ena, dis_ready;
    logic       dis_rs1en, dis_rs2en, dis_rdwen, dis_qfren;
    logic [4:0] dis_rs1idx, dis_rs2idx, dis_rdidx;
    logic [7:0] dis_qubitlist;
    logic [1:0] dis_ptr;
    logic       ret_ena;
    logic [1:0] ret_ptr;
    logic       ret_rdwen, ret_qfren;
    logic [4:0] ret_rdidx;
    logic [7:0] ret_qubitlist;
    logic       oitf_empty;
    logic       m_rs1, m_rs2, m_rd, m_ql;

    int vectors;
    int miscompares;

    qpu_exu_oitf #(.DEPTH(4), .PTR_W(2), .RFIDX_W(5), .QUBIT_NUM(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dis_ena              (dis_ena),
        .dis_ready            (dis_ready),
        .dis_rs1en            (dis_rs1en),
        .dis_rs2en            (dis_rs2en),
        .dis_rdwen            (dis_rdwen),
        .dis_qfren            (dis_qfren),
        .dis_rs1idx           (dis_rs1idx),
        .dis_rs2idx           (dis_rs2idx),
        .dis_rdidx            (dis_rdidx),
        .dis_qubitlist        (dis_qubitlist),
        .dis_ptr              (dis_ptr),
        .ret_ena              (ret_ena),
        .ret_ptr              (ret_ptr),
        .ret_rdwen            (ret_rdwen),
        .ret_qfren            (ret_qfren),
        .ret_rdidx            (ret_rdidx),
        .ret_qubitlist        (ret_qubitlist),
        .oitf_empty           (oitf_empty),
        .oitfrd_match_disprs1 (m_rs1),
        .oitfrd_match_disprs2 (m_rs2),
        .oitfrd_match_disprd  (m_rd),
        .oitfqf_match_dispql  (m_ql)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dis_ena = 0; ret_ena = 0;
        dis_rs1en = 0; dis_rs2en = 0; dis_rdwen = 0; dis_qfren = 0;
        dis_rs1idx = 0; dis_rs2idx = 0; dis_rdidx = 0; dis_qubitlist = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic rdw, input logic qf, input logic [7:0] ql);
        idle();
        dis_ena = 1; dis_rdidx = rd; dis_rdwen = rdw; dis_qfren = qf; dis_qubitlist = ql;
        tick();
        idle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle();
        rst_n = 0;

        // reset state
        #12;
        dis_rs1en = 1; dis_rs2en = 1; dis_rdwen = 1; dis_qubitlist = 8'hff;
        #1;
        chk("rst_ready", dis_ready, 1);
        chk("rst_empty", oitf_empty, 1);
        chk("rst_dis_ptr", dis_ptr, 0);
        chk("rst_ret_ptr", ret_ptr, 0);
        chk("rst_matches", {m_rs1, m_rs2, m_rd, m_ql}, 0);
        idle();
        @(negedge clk);
        rst_n = 1;
        tick();

        // fill with rdidx 1..4
        for (int i = 0; i < 4; i++) begin
            dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5'(i + 1);
            #1;
            chk($sformatf("fill_ptr%0d", i), dis_ptr, i);
            chk($sformatf("fill_ready%0d", i), dis_ready, 1);
            tick();
        end
        idle();
        chk("full_ready", dis_ready, 0);
        chk("full_empty", oitf_empty, 0);

        // 5th allocate ignored
        dis_ena = 1; dis_rdwen = 1; dis_rdidx = 9;
        #1;
        chk("full_dis_ptr", dis_ptr, 0);
        tick();
        idle();
        chk("full_ready_hold", dis_ready, 0);
        chk("full_dis_ptr_hold", dis_ptr, 0);

        // drain in FIFO order
        for (int i = 0; i < 4; i++) begin
            ret_ena = 1;
            #1;
            chk($sformatf("drain_rdidx%0d", i), ret_rdidx, i + 1);
            chk($sformatf("drain_ptr%0d", i), ret_ptr, i);
            tick();
        end
        idle();
        chk("drain_empty", oitf_empty, 1);

        // RAW/WAW: allocating entry does not match itself
        dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5; dis_rs1en = 1; dis_rs1idx = 5;
        #1;
        chk("self_no_match_rs1", m_rs1, 0);
        chk("self_no_match_rd", m_rd, 0);
        tick();
        idle();
        dis_rs1en = 1; dis_rs1idx = 5;
        #1;
        chk("raw_rs1", m_rs1, 1);
        dis_rs1en = 0;
        #1;
        chk("raw_rs1_disabled", m_rs1, 0);
        dis_rs2en = 1; dis_rs2idx = 5;
        #1;
        chk("raw_rs2", m_rs2, 1);
        dis_rs2idx = 6;
        #1;
        chk("raw_rs2_other", m_rs2, 0);
        dis_rdwen = 1; dis_rdidx = 5;
        #1;
        chk("waw_rd", m_rd, 1);
        dis_rdwen = 0;
        #1;
        chk("waw_rd_disabled", m_rd, 0);
        idle();
        dis_rs1en = 1; dis_rs1idx = 5; ret_ena = 1;
        #1;
        chk("retiring_still_matches", m_rs1, 1);
        tick();
        ret_ena = 0; dis_rs2en = 1; dis_rs2idx = 5; dis_rdwen = 1; dis_rdidx = 5; dis_qubitlist = 8'hff;
        #1;
        chk("retired_matches", {m_rs1, m_rs2, m_rd, m_ql}, 0);
        idle();

        // qubit conflict
        alloc(5'd0, 1'b0, 1'b1, 8'b0000_0010);
        dis_qubitlist = 8'b0000_0110;
        #1;
        chk("ql_overlap", m_ql, 1);
        dis_qubitlist = 8'b0000_0001;
        #1;
        chk("ql_disjoint", m_ql, 0);
        dis_rs1en = 1; dis_rs1idx = 0;
        #1;
        chk("ql_entry_no_rd_match", m_rs1, 0);
        idle();
        alloc(5'd0, 1'b0, 1'b0, 8'b0000_0001);
        dis_qubitlist = 8'b0000_0001;
        #1;
        chk("ql_qfren0_no_match", m_ql, 0);
        chk("ql_head_qfren", ret_qfren, 1);
        chk("ql_head_list", ret_qubitlist, 8'b0000_0010);
        idle();
        ret_ena = 1;
        tick();
        tick();
        idle();
        chk("ql_drained", oitf_empty, 1);
        chk("ql_ret_ptr", ret_ptr, 3);

        // three entries, then simultaneous allocate+retire across the wrap
        alloc(5'd20, 1'b1, 1'b0, 8'h00);
        alloc(5'd21, 1'b1, 1'b0, 8'h00);
        alloc(5'd22, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5'(23 + k); ret_ena = 1;
            #1;
            chk($sformatf("sim_rdidx%0d", k), ret_rdidx, 20 + k);
            chk($sformatf("sim_ptr%0d", k), ret_ptr, (3 + k) % 4);
            tick();
            chk($sformatf("sim_ready%0d", k), dis_ready, 1);
        end
        idle();
        chk("sim_empty", oitf_empty, 0);
        alloc(5'd31, 1'b1, 1'b0, 8'h00);
        chk("sim_occ3_now_full", dis_ready, 0);

        // full: only the retire happens
        dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5'd17; ret_ena = 1;
        #1;
        chk("fb_head", ret_rdidx, 28);
        tick();
        idle();
        chk("fb_ready", dis_ready, 1);
        for (int i = 0; i < 3; i++) begin
            ret_ena = 1;
            #1;
            chk($sformatf("fb_drain%0d", i), ret_rdidx, 29 + i);
            tick();
        end
        idle();
        chk("fb_empty", oitf_empty, 1);
        chk("fb_ret_ptr", ret_ptr, 3);

        // retire while empty ignored
        ret_ena = 1;
        tick();
        idle();
        chk("empty_ret_empty", oitf_empty, 1);
        chk("empty_ret_ptr", ret_ptr, 3);
        chk("empty_ret_ready", dis_ready, 1);

        // asynchronous reset mid-operation
        alloc(5'd12, 1'b1, 1'b1, 8'h0f);
        alloc(5'd13, 1'b1, 1'b0, 8'h00);
        dis_rs1en = 1; dis_rs1idx = 12; dis_qubitlist = 8'h01;
        #1;
        chk("pre_rst_rs1", m_rs1, 1);
        chk("pre_rst_ql", m_ql, 1);
        chk("pre_rst_dis_ptr", dis_ptr, 1);
        #1;
        rst_n = 0;
        #1;
        chk("arst_ready", dis_ready, 1);
        chk("arst_empty", oitf_empty, 1);
        chk("arst_ptrs", {dis_ptr, ret_ptr}, 0);
        chk("arst_ret", {ret_rdwen, ret_qfren, ret_rdidx, ret_qubitlist}, 0);
        chk("arst_matches", {m_rs1, m_ql}, 0);
        idle();
        @(negedge clk);
        rst_n = 1;
        tick();
        dis_ena = 1; dis_rdwen = 1; dis_rdidx = 7;
        #1;
        chk("post_rst_dis_ptr", dis_ptr, 0);
        tick();
        idle();
        chk("post_rst_head", ret_rdidx, 7);
        chk("post_rst_empty", oitf_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qpu_exu_oitf.md
# qpu_exu_oitf

Outstanding Instruction Track FIFO for the QPU execute stage. It records every long-pipe instruction the dispatch unit issues: classical loads and FMR that write a classical register, and measure instructions that set qubit flags. It retires those entries in order as their results write back. It also drives the hazard-match signals (`oitfrd_match_disprs1/rs2/rd`, `oitfqf_match_dispql`) that let dispatch stall RAW/WAW hazards on registers and qubit-flag conflicts.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be a power of 2, at least 2.
- `PTR_W`, 2: log2(DEPTH).
- `RFIDX_W`, 5: register index width (`QPU_RFIDX_REAL_WIDTH`).
- `QUBIT_NUM`, 8: qubit-list width (`QPU_QUBIT_NUM`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `dis_ena`  in  1: allocate one entry this cycle. Dispatch only asserts it when `dis_ready`=1.
- `dis_ready`  out  1: at least one entry is free.
- `dis_rs1en`, `dis_rs2en`  in  1: the dispatching instruction reads rs1/rs2.
- `dis_rdwen`  in  1: the dispatching instruction writes rd; stored in the entry.
- `dis_qfren`  in  1: the dispatching instruction sets qubit flags (measure); stored.
- `dis_rs1idx`, `dis_rs2idx`, `dis_rdidx`  in  RFIDX_W: register indices of the dispatching instruction.
- `dis_qubitlist`  in  QUBIT_NUM: qubit list of the dispatching instruction; stored.
- `dis_ptr`  out  PTR_W: index of the entry being allocated; it is the tag carried down the long pipe.
- `ret_ena`  in  1: the head entry has written back; pop it.
- `ret_ptr`  out  PTR_W: head entry index.
- `ret_rdwen`, `ret_qfren`  out  1: flags stored in the head entry.
- `ret_rdidx`  out  RFIDX_W: rd index stored in the head entry.
- `ret_qubitlist`  out  QUBIT_NUM: qubit list stored in the head entry.
- `oitf_empty`  out  1: no valid entries.
- `oitfrd_match_disprs1`  out  1: a valid entry with rdwen=1 has rdidx==`dis_rs1idx`, and `dis_rs1en`=1.
- `oitfrd_match_disprs2`  out  1: the same check against rs2, qualified by `dis_rs2en`.
- `oitfrd_match_disprd`  out  1: a valid entry with rdwen=1 has rdidx==`dis_rdidx`, and `dis_rdwen`=1.
- `oitfqf_match_dispql`  out  1: a valid entry with qfren=1 overlaps the dispatching instruction, i.e. `(entry.qubitlist & dis_qubitlist)`≠0.

## Operation
- Storage: DEPTH entries. Each entry holds {valid, rdwen, qfren, rdidx, qubitlist}.
- Pointers: `alc_ptr` and `ret_ptr_r`, each PTR_W bits plus one wrap bit.
  - full = indices equal and wrap bits differ.
  - empty = both pointers fully equal.
- Allocate (`dis_ena`=1 and not full):
  - Write the dis_* fields into entry `alc_ptr` and set valid=1.
  - Increment `alc_ptr`; the wrap bit toggles on index DEPTH-1 → 0.
- Retire (`ret_ena`=1 and not empty):
  - Clear valid of entry `ret_ptr_r`.
  - Increment `ret_ptr_r`, with the same wrap rule.
- Allocate and retire may happen in the same cycle; both take effect and occupancy is unchanged.
- `dis_ready` = !full. It depends only on registered state; a same-cycle retire does not free a slot for a same-cycle allocate.
- `dis_ena` while full is ignored: no write, no pointer change.
- `ret_ena` while empty is ignored.
- Match outputs:
  - Combinational OR over all valid entries, using the current registered contents.
  - An entry being retired this cycle still matches.
  - The entry being allocated this cycle never matches itself.
- Matches are qualified by the per-source enables. If the source enable is 0, the match output is 0.
- Reset (`rst_n`=0, asynchronous, may occur mid-operation):
  - Clear all valid bits, both pointers, and all stored fields to 0.
  - Outputs after reset: `dis_ready`=1, `oitf_empty`=1, `dis_ptr`=0, `ret_ptr`=0, all `ret_*`=0, all match outputs=0.

## Timing
- Allocate and retire take effect at the rising edge of `clk`.
- State-derived outputs (`dis_ready`, `oitf_empty`, `ret_*`) update the cycle after the edge.
- `dis_ptr`/`ret_ptr` are the index bits of the current pointers. `dis_ptr` is valid in the same cycle as `dis_ena`.
- Match outputs are combinational from the dis_* inputs and registered state, with zero-cycle latency to dispatch.
- There are no other combinational input→output paths.
- Throughput is one allocate plus one retire per cycle.

## Test plan
- Reset, then fill:
  - After reset: `dis_ready`=1, `oitf_empty`=1, all matches 0.
  - Allocate 4 entries with rdidx 1..4. `dis_ptr` steps 0,1,2,3; `dis_ready`=0 after the 4th.
  - A 5th `dis_ena` is ignored and `dis_ptr` stays 0.
- RAW/WAW detection:
  - Store the entry rdidx=5, rdwen=1.
  - Dispatch rs1idx=5, rs1en=1 → `oitfrd_match_disprs1`=1.
  - The same with rs1en=0 → 0.
  - rdidx=5, rdwen=1 → `oitfrd_match_disprd`=1.
  - Retire the entry → all matches 0 the next cycle.
- Qubit conflict:
  - Store a measure entry with qfren=1, qubitlist=8'b0000_0010.
  - Dispatch qubitlist 8'b0000_0110 → `oitfqf_match_dispql`=1.
  - Dispatch 8'b0000_0001 → 0.
  - A stored entry with qfren=0 never matches.
- Simultaneous ops and wrap-around:
  - With 3 entries valid, assert `dis_ena` and `ret_ena` together for 8 cycles.
  - Occupancy stays 3 and `ret_ptr` wraps 3→0.
  - `ret_rdidx` follows FIFO order across the wrap.
- Full boundary:
  - When full, assert `dis_ena` and `ret_ena` together. Only the retire occurs; `dis_ready`=1 the next cycle.
  - When empty, `ret_ena` is ignored and `oitf_empty` stays 1.
- Reset mid-operation:
  - Assert `rst_n`=0 asynchronously with 2 valid entries.
  - Outputs reach reset values immediately, without a clock edge.
  - After release, the next allocate uses `dis_ptr`=0.
